// File: rtl/branch_alu_ctrl_unit.sv
// ID->EX decode register: ALU control, relative branch target, branch condition
// and next-PC selection for the 8-bit accumulator pipeline, all in one stage.
module branch_alu_ctrl_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic [15:0] instr,
    input  logic [9:0]  pc,
    input  logic        za,
    input  logic        zb,
    input  logic        ca,
    input  logic        cb,
    input  logic        na,
    input  logic        nb,
    output logic [2:0]  alu_ctl,
    output logic        is_branch,
    output logic        is_jump,
    output logic        taken,
    output logic [9:0]  branch_target,
    output logic [9:0]  next_pc
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_PASS = 3'd7;
    localparam logic [3:0] COND_JUMP = 4'hF;

    logic [5:0] opcode;
    logic [9:0] cst;
    logic [3:0] cond;

    logic [2:0] alu_ctl_d,       alu_ctl_q;
    logic       is_branch_d,     is_branch_q;
    logic       is_jump_d,       is_jump_q;
    logic       taken_d,         taken_q;
    logic [9:0] branch_target_d, branch_target_q;
    logic [9:0] next_pc_d,       next_pc_q;

    assign opcode = instr[15:10];
    assign cst    = instr[9:0];
    assign cond   = opcode[3:0];

    function automatic logic [2:0] alu_decode(input logic [5:0] op);
        logic [2:0] code;
        case (op[5:4])
            2'b00, 2'b01: code = op[4:2];
            2'b10:        code = ALU_ADD;
            default:      code = ALU_PASS;
        endcase
        return code;
    endfunction

    // Conditions C..E are reserved and never redirect; JUMP is handled separately.
    function automatic logic cond_met(
        input logic [3:0] c,
        input logic       fza, input logic fzb,
        input logic       fca, input logic fcb,
        input logic       fna, input logic fnb
    );
        logic r;
        case (c)
            4'h0: r = fza;
            4'h1: r = !fza;
            4'h2: r = fca;
            4'h3: r = !fca;
            4'h4: r = fna;
            4'h5: r = !fna;
            4'h6: r = fzb;
            4'h7: r = !fzb;
            4'h8: r = fcb;
            4'h9: r = !fcb;
            4'hA: r = fnb;
            4'hB: r = !fnb;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_ctl_d       = alu_decode(opcode);
        is_branch_d     = 1'b0;
        is_jump_d       = 1'b0;
        taken_d         = 1'b0;
        branch_target_d = pc + cst;
        next_pc_d       = pc + 10'd1;

        if (opcode[5:4] == 2'b11) begin
            if (cond == COND_JUMP) begin
                is_jump_d = 1'b1;
                taken_d   = 1'b1;
                next_pc_d = cst;
            end else begin
                is_branch_d = 1'b1;
                taken_d     = cond_met(cond, za, zb, ca, cb, na, nb);
                if (taken_d) begin
                    next_pc_d = branch_target_d;
                end
            end
        end
    end

    // Pipeline register: flush inserts the reset-valued bubble even when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctl_q       <= ALU_ADD;
            is_branch_q     <= 1'b0;
            is_jump_q       <= 1'b0;
            taken_q         <= 1'b0;
            branch_target_q <= '0;
            next_pc_q       <= '0;
        end else if (flush) begin
            alu_ctl_q       <= ALU_ADD;
            is_branch_q     <= 1'b0;
            is_jump_q       <= 1'b0;
            taken_q         <= 1'b0;
            branch_target_q <= '0;
            next_pc_q       <= '0;
        end else if (en) begin
            alu_ctl_q       <= alu_ctl_d;
            is_branch_q     <= is_branch_d;
            is_jump_q       <= is_jump_d;
            taken_q         <= taken_d;
            branch_target_q <= branch_target_d;
            next_pc_q       <= next_pc_d;
        end
    end

    assign alu_ctl       = alu_ctl_q;
    assign is_branch     = is_branch_q;
    assign is_jump       = is_jump_q;
    assign taken         = taken_q;
    assign branch_target = branch_target_q;
    assign next_pc       = next_pc_q;

endmodule

// File: tb/tb_branch_alu_ctrl_unit.sv
// Bench for branch_alu_ctrl_unit: directed steps plus randomized traffic against
// a table-driven reference model of the decode/branch rules.
module tb_branch_alu_ctrl_unit;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr = '0;
    logic [9:0]  pc = '0;
    logic        za = 0, zb = 0, ca = 0, cb = 0, na = 0, nb = 0;
    logic [2:0]  alu_ctl;
    logic        is_branch, is_jump, taken;
    logic [9:0]  branch_target, next_pc;

    int total = 0;
    int bad = 0;

    // expected register contents
    logic [2:0] e_alu;
    logic       e_br, e_jmp, e_tk;
    logic [9:0] e_tgt, e_npc;

    branch_alu_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .instr(instr), .pc(pc),
        .za(za), .zb(zb), .ca(ca), .cb(cb), .na(na), .nb(nb),
        .alu_ctl(alu_ctl), .is_branch(is_branch), .is_jump(is_jump),
        .taken(taken), .branch_target(branch_target), .next_pc(next_pc)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu_ctl"}, int'(alu_ctl), int'(e_alu));
        chk({tag, ".is_branch"}, int'(is_branch), int'(e_br));
        chk({tag, ".is_jump"}, int'(is_jump), int'(e_jmp));
        chk({tag, ".taken"}, int'(taken), int'(e_tk));
        chk({tag, ".branch_target"}, int'(branch_target), int'(e_tgt));
        chk({tag, ".next_pc"}, int'(next_pc), int'(e_npc));
    endtask

    task automatic model_clear();
        e_alu = 0; e_br = 0; e_jmp = 0; e_tk = 0; e_tgt = 0; e_npc = 0;
    endtask

    // Rules written from the opcode table: flags ordered by condition pair index.
    task automatic model_load(input logic [15:0] ins, input logic [9:0] p, input logic [5:0] f);
        int op, k, c, fl_idx;
        bit flag_arr [6];
        op = int'(ins[15:10]);
        k  = int'(ins[9:0]);
        flag_arr[0] = f[5]; flag_arr[1] = f[4]; flag_arr[2] = f[3];
        flag_arr[3] = f[2]; flag_arr[4] = f[1]; flag_arr[5] = f[0];
        if (op < 32)      e_alu = 3'(op / 4);
        else if (op < 48) e_alu = 3'd0;
        else              e_alu = 3'd7;
        e_tgt = 10'((int'(p) + k) % 1024);
        e_br = 0; e_jmp = 0; e_tk = 0;
        if (op >= 48) begin
            c = op - 48;
            if (c == 15) begin
                e_jmp = 1; e_tk = 1;
            end else begin
                e_br = 1;
                if (c < 12) begin
                    fl_idx = c / 2;
                    e_tk = (c % 2 == 0) ? flag_arr[fl_idx] : !flag_arr[fl_idx];
                end
            end
        end
        if (e_jmp)     e_npc = 10'(k);
        else if (e_tk) e_npc = e_tgt;
        else           e_npc = 10'((int'(p) + 1) % 1024);
    endtask

    // f = {za, ca, na, zb, cb, nb}
    task automatic step(input logic [15:0] ins, input logic [9:0] p, input logic [5:0] f,
                        input logic e, input logic fl, input string tag);
        @(negedge clk);
        instr = ins; pc = p; en = e; flush = fl;
        za = f[5]; ca = f[4]; na = f[3]; zb = f[2]; cb = f[1]; nb = f[0];
        if (fl)     model_clear();
        else if (e) model_load(ins, p, f);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        model_clear();
        check_all("reset_noclk");
        rst_n = 1'b1;
        #2 clk_run = 1'b1;

        step(16'h0000, 10'd5, 6'h00, 1'b1, 1'b0, "first");
        chk("first.npc_lit", int'(next_pc), 6);

        step({6'h04, 10'd0}, 10'd0, 6'h00, 1'b1, 1'b0, "op04");
        chk("op04.lit", int'(alu_ctl), 1);
        step({6'h1C, 10'd9}, 10'd7, 6'h00, 1'b1, 1'b0, "op1C");
        chk("op1C.lit", int'(alu_ctl), 7);
        step({6'h20, 10'd9}, 10'd7, 6'h00, 1'b1, 1'b0, "op20");
        chk("op20.lit", int'(alu_ctl), 0);
        step({6'h31, 10'd9}, 10'd7, 6'h00, 1'b1, 1'b0, "op31");
        chk("op31.lit", int'(alu_ctl), 7);

        for (int op = 0; op < 64; op++)
            step({6'(op), 10'($urandom_range(0, 1023))}, 10'($urandom_range(0, 1023)),
                 6'($urandom_range(0, 63)), 1'b1, 1'b0, "sweep");

        step({6'b110000, 10'd20}, 10'd100, 6'b100000, 1'b1, 1'b0, "baeq_t");
        chk("baeq_t.npc_lit", int'(next_pc), 120);
        step({6'b110000, 10'd20}, 10'd100, 6'b000000, 1'b1, 1'b0, "baeq_n");
        chk("baeq_n.npc_lit", int'(next_pc), 101);

        step({6'b111111, 10'd777}, 10'd3, 6'h00, 1'b1, 1'b0, "jump");
        chk("jump.npc_lit", int'(next_pc), 777);
        step({6'b111011, 10'd50}, 10'd1000, 6'b111110, 1'b1, 1'b0, "bbpl_wrap");
        chk("bbpl_wrap.npc_lit", int'(next_pc), 26);

        for (int c = 12; c < 15; c++)
            step({2'b11, 4'(c), 10'd33}, 10'd200, 6'h3F, 1'b1, 1'b0, "reserved");

        step({6'b110000, 10'd20}, 10'd100, 6'b100000, 1'b1, 1'b0, "pre_stall");
        step({6'b000100, 10'd5}, 10'd400, 6'h00, 1'b0, 1'b0, "stall1");
        step({6'b111111, 10'd9}, 10'd401, 6'h00, 1'b0, 1'b0, "stall2");
        step({6'b110000, 10'd20}, 10'd100, 6'b100000, 1'b1, 1'b1, "flush_en");
        step({6'b110000, 10'd20}, 10'd100, 6'b100000, 1'b1, 1'b0, "pre_flush");
        step({6'b110000, 10'd20}, 10'd100, 6'b100000, 1'b0, 1'b1, "flush_stall");

        step({6'b111111, 10'd555}, 10'd11, 6'h00, 1'b1, 1'b0, "pre_areset");
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all("areset_mid");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 300; i++)
            step(16'($urandom), 10'($urandom), 6'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
